// File: rtl/gpio_rsp_packer_pkg.sv
// ---------------------------------------------------------------------------
// gpio_rsp_packer_pkg
//   Shared definitions for the GPIO response packer:
//   - response packet field offsets/widths (ID, SEQ, CNT, DATA)
//   - FSM state encoding (COLLECT / SEND)
//   - default peripheral ID for the GPIO block
//   - pack_pkt(): assembles a packet from its fields
// ---------------------------------------------------------------------------
package gpio_rsp_packer_pkg;

   localparam int PKT_W    = 51;

   localparam int ID_LSB   = 48;
   localparam int ID_W     = 3;
   localparam int SEQ_LSB  = 40;
   localparam int SEQ_W    = 8;
   localparam int CNT_LSB  = 32;
   localparam int CNT_W    = 8;
   localparam int DATA_LSB = 0;
   localparam int DATA_W   = 32;

   localparam logic [ID_W-1:0] GPIO_PERIPH_ID = 3'd2;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_SEND    = 1'b1
   } state_t;

   function automatic logic [PKT_W-1:0] pack_pkt(
      input logic [ID_W-1:0]   id,
      input logic [SEQ_W-1:0]  seq,
      input logic [CNT_W-1:0]  cnt,
      input logic [DATA_W-1:0] data
   );
      logic [PKT_W-1:0] p;
      p                       = '0;
      p[ID_LSB   +: ID_W]     = id;
      p[SEQ_LSB  +: SEQ_W]    = seq;
      p[CNT_LSB  +: CNT_W]    = cnt;
      p[DATA_LSB +: DATA_W]   = data;
      return p;
   endfunction

endpackage : gpio_rsp_packer_pkg

// File: rtl/gpio_rsp_packer_timeout.sv
// ---------------------------------------------------------------------------
// gpio_rsp_packer_timeout
//   Idle counter used to flush partial response packets. Only instantiated
//   when GPIO_RSP_TIMEOUT_EN is defined.
//   The counter clears on clr, counts up while en is high, and saturates at
//   TIMEOUT_CYCLES-1 (never wraps). expire is high while saturated.
// Ports
//   clk1    in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   clr     in   synchronous clear (priority over en)
//   en      in   count enable
//   expire  out  counter == TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module gpio_rsp_packer_timeout
   import gpio_rsp_packer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk1,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int             CW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && (count_q != LAST)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign expire = (count_q == LAST);

endmodule : gpio_rsp_packer_timeout

// File: rtl/gpio_rsp_packer.sv
// ---------------------------------------------------------------------------
// gpio_rsp_packer
//   Drains the GPIO read FIFO one byte per cycle, packs up to PKT_BYTES bytes
//   into a 51-bit response packet and offers it on a valid/ready interface.
//   Packet map: [50:48] PERIPH_ID, [47:40] seq, [39:32] byte count,
//               [31:0] bytes with byte0 at [7:0], unused slots zero.
//   Build option GPIO_RSP_TIMEOUT_EN: when defined, a partial packet is
//   flushed after TIMEOUT_CYCLES idle cycles; when undefined only full
//   packets are emitted and trailing bytes wait for more data.
// Ports
//   clk1               in   clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   rd_gpio_f_empty    in   GPIO read FIFO empty
//   rd_gpio_fifo_data  in   FIFO read data, valid the cycle after rd_gpio_fifo_en
//   rd_gpio_fifo_en    out  FIFO read strobe, one byte per asserted cycle
//   pkt_valid          out  response packet available
//   pkt_ready          in   TX path accepts when pkt_valid & pkt_ready
//   pkt_data           out  response packet, stable while pkt_valid
//   pkt_sent           out  one-cycle pulse on the accept cycle
// ---------------------------------------------------------------------------
module gpio_rsp_packer
   import gpio_rsp_packer_pkg::*;
#(
   parameter int              GPIO_FIFO_WIDTH   = 8,
   parameter int              DATA_PACKET_WIDTH = 51,
   parameter int              PKT_BYTES         = 4,
   parameter int              TIMEOUT_CYCLES    = 64,
   parameter logic [ID_W-1:0] PERIPH_ID         = GPIO_PERIPH_ID
) (
   input  logic                         clk1,
   input  logic                         rst_n,
   input  logic                         rd_gpio_f_empty,
   input  logic [GPIO_FIFO_WIDTH-1:0]   rd_gpio_fifo_data,
   output logic                         rd_gpio_fifo_en,
   output logic                         pkt_valid,
   input  logic                         pkt_ready,
   output logic [DATA_PACKET_WIDTH-1:0] pkt_data,
   output logic                         pkt_sent
);

   localparam int         SLOT_BITS   = PKT_BYTES * GPIO_FIFO_WIDTH;
   localparam logic [2:0] PKT_BYTES_C = 3'(PKT_BYTES);

   // Elaboration-time parameter sanity checks.
   if (PKT_BYTES < 1 || PKT_BYTES > 4 || SLOT_BITS > DATA_W) begin : g_bad_pkt_bytes
      $error("gpio_rsp_packer: PKT_BYTES out of range");
   end
   if (DATA_PACKET_WIDTH != PKT_W) begin : g_bad_pkt_width
      $error("gpio_rsp_packer: DATA_PACKET_WIDTH must be 51");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("gpio_rsp_packer: TIMEOUT_CYCLES must be >= 2");
   end

   state_t                                  state_q, state_d;
   logic   [2:0]                            cnt_q;
   logic                                    inflight_q;
   logic   [SEQ_W-1:0]                      seq_q;
   logic   [PKT_BYTES-1:0][GPIO_FIFO_WIDTH-1:0] slots_q;

   logic                                    rd_en;
   logic                                    capture;
   logic                                    accept;
   logic                                    room;
   logic                                    flush;
   logic   [DATA_W-1:0]                     data_field;

   // A byte requested last cycle is on the data bus now.
   assign capture = inflight_q;
   assign accept  = (state_q == ST_SEND) && pkt_ready;
   // Count the byte in flight so a full packet never over-reads the FIFO.
   assign room    = ({1'b0, cnt_q} + {3'b000, inflight_q}) < {1'b0, PKT_BYTES_C};

`ifdef GPIO_RSP_TIMEOUT_EN
   logic expire;

   gpio_rsp_packer_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk1   (clk1),
      .rst_n  (rst_n),
      .clr    (capture || (cnt_q == 3'd0)),
      .en     ((state_q == ST_COLLECT) && (cnt_q != 3'd0) && !inflight_q),
      .expire (expire)
   );

   // Flush only a non-empty partial packet with nothing left on the bus.
   assign flush = expire && (state_q == ST_COLLECT) && (cnt_q != 3'd0) && !inflight_q;
`else
   assign flush = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and read strobe
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            rd_en = !rd_gpio_f_empty && room && !flush;
            // Final byte lands this cycle: SEND is entered on the same edge.
            if (capture && ((cnt_q + 3'd1) == PKT_BYTES_C)) begin
               state_d = ST_SEND;
            end else if (flush) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (pkt_ready) begin
               state_d = ST_COLLECT;
            end
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   // Byte slots, count, in-flight flag and sequence number
   // NOTE: the slot registers are reset (not left as uninitialised storage)
   // because unused slots of a partial packet must read as zero.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= 3'd0;
         inflight_q <= 1'b0;
         seq_q      <= '0;
         slots_q    <= '0;
      end else begin
         inflight_q <= rd_en;
         if (accept) begin
            cnt_q   <= 3'd0;
            seq_q   <= seq_q + 1'b1;
            slots_q <= '0;
         end else if (capture) begin
            for (int i = 0; i < PKT_BYTES; i++) begin
               if (cnt_q == 3'(i)) begin
                  slots_q[i] <= rd_gpio_fifo_data;
               end
            end
            cnt_q <= cnt_q + 3'd1;
         end
      end
   end

   always_comb begin
      data_field                = '0;
      data_field[SLOT_BITS-1:0] = slots_q;
   end

   // The strobe is forced low while reset is held so no byte is popped.
   assign rd_gpio_fifo_en = rd_en && rst_n;
   assign pkt_valid       = (state_q == ST_SEND);
   assign pkt_sent        = accept;
   // All packet fields come straight from registers that are frozen in SEND,
   // so pkt_data cannot change until the accept edge.
   assign pkt_data        = pkt_valid ? pack_pkt(PERIPH_ID, seq_q, {5'd0, cnt_q}, data_field)
                                      : '0;

endmodule : gpio_rsp_packer

// File: tb/tb_gpio_rsp_packer.sv
// ---------------------------------------------------------------------------
// tb_gpio_rsp_packer
//   Self-checking bench for gpio_rsp_packer. A byte-queue reference model
//   turns every byte pushed into the FIFO into expected packets; a monitor
//   pops and compares on every accept. Build with GPIO_RSP_TIMEOUT_EN to
//   exercise the partial-packet flush.
// ---------------------------------------------------------------------------
module tb_gpio_rsp_packer;

   localparam int PKT_BYTES      = 4;
   localparam int TIMEOUT_CYCLES = 64;

   logic        clk1 = 1'b0;
   logic        rst_n;
   logic        rd_gpio_f_empty;
   logic [7:0]  fifo_rdata = 8'h00;
   logic        rd_en;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [50:0] pkt_data;
   logic        pkt_sent;

   int n_cmp = 0;
   int n_err = 0;

   // FIFO model
   logic [7:0] fifo_mem [0:16383];
   int         rd_ptr = 0;
   int         wr_ptr = 0;
   assign rd_gpio_f_empty = (rd_ptr == wr_ptr);

   // Reference model: bytes not yet packed, expected packets, next seq
   logic [7:0]  pending [$];
   logic [50:0] exp_q   [$];
   logic [7:0]  model_seq = 8'd0;

   int          sent_pulses = 0;
   logic [7:0]  last_seq    = 8'hFF;

   gpio_rsp_packer #(
      .GPIO_FIFO_WIDTH   (8),
      .DATA_PACKET_WIDTH (51),
      .PKT_BYTES         (PKT_BYTES),
      .TIMEOUT_CYCLES    (TIMEOUT_CYCLES),
      .PERIPH_ID         (3'd2)
   ) dut (
      .clk1              (clk1),
      .rst_n             (rst_n),
      .rd_gpio_f_empty   (rd_gpio_f_empty),
      .rd_gpio_fifo_data (fifo_rdata),
      .rd_gpio_fifo_en   (rd_en),
      .pkt_valid         (pkt_valid),
      .pkt_ready         (pkt_ready),
      .pkt_data          (pkt_data),
      .pkt_sent          (pkt_sent)
   );

   initial forever #5 clk1 = ~clk1;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Turn the pending bytes into one expected packet.
   function automatic void emit();
      logic [31:0] d;
      d = '0;
      foreach (pending[i]) d[8*i +: 8] = pending[i];
      exp_q.push_back({3'd2, model_seq, 8'(pending.size()), d});
      model_seq = model_seq + 8'd1;
      pending.delete();
   endfunction

   task automatic push_byte(input logic [7:0] b);
      fifo_mem[wr_ptr] = b;
      wr_ptr++;
      pending.push_back(b);
      if (pending.size() == PKT_BYTES) emit();
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic rand_tick();
      tick();
      pkt_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!pkt_valid && n < 100) begin
         @(negedge clk1);
         n++;
      end
      check(name, pkt_valid, 1'b1);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rd_ptr != wr_ptr) && n < 4000) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // Asynchronous reset: outputs must drop before any clock edge. The model
   // forgets everything except bytes still sitting in the FIFO.
   task automatic do_reset(input string name);
      rst_n = 1'b0;
      #1;
      check({name, "_rd_en"},     rd_en,     1'b0);
      check({name, "_pkt_valid"}, pkt_valid, 1'b0);
      check({name, "_pkt_data"},  pkt_data,  '0);
      check({name, "_pkt_sent"},  pkt_sent,  1'b0);
      pending.delete();
      exp_q.delete();
      model_seq = 8'd0;
      for (int i = rd_ptr; i < wr_ptr; i++) begin
         pending.push_back(fifo_mem[i]);
         if (pending.size() == PKT_BYTES) emit();
      end
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   // FIFO read port: data is valid the cycle after the strobe.
   initial forever begin
      @(posedge clk1);
      if (rd_en && (rd_ptr != wr_ptr)) begin
         fifo_rdata <= fifo_mem[rd_ptr];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   // Monitor / scoreboard
   initial begin
      logic        hold;
      logic [50:0] held_data;
      logic [50:0] e;
      hold      = 1'b0;
      held_data = '0;
      forever begin
         @(negedge clk1);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (rd_en) check("rd_en_only_when_nonempty", rd_gpio_f_empty, 1'b0);
            if (hold) begin
               check("valid_held_until_accept", pkt_valid, 1'b1);
               check("data_stable_until_accept", pkt_data, held_data);
            end
            if (pkt_valid) check("no_read_in_send", rd_en, 1'b0);
            if (pkt_sent) sent_pulses++;
            if (pkt_valid && pkt_ready) begin
               check("pkt_sent_on_accept", pkt_sent, 1'b1);
               last_seq = pkt_data[47:40];
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_packet: got %h, expected no packet", pkt_data);
               end else begin
                  e = exp_q.pop_front();
                  check("pkt_data", pkt_data, e);
               end
            end else begin
               check("no_spurious_pkt_sent", pkt_sent, 1'b0);
            end
            hold      = pkt_valid && !pkt_ready;
            held_data = pkt_data;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected bench to finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0;
      int n;
      rst_n     = 1'b0;
      pkt_ready = 1'b0;

      // ---- Test 1: preloaded 11,22,33,44 with ready high ----
      push_byte(8'h11);
      push_byte(8'h22);
      push_byte(8'h33);
      push_byte(8'h44);
      repeat (3) tick();
      check("reset_rd_en",     rd_en,     1'b0);
      check("reset_pkt_valid", pkt_valid, 1'b0);
      check("reset_pkt_data",  pkt_data,  '0);
      check("reset_pkt_sent",  pkt_sent,  1'b0);
      pkt_ready = 1'b1;
      rst_n     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk1);
         check("t1_rd_en_burst", rd_en, 1'b1);
      end
      @(negedge clk1);
      check("t1_rd_en_stops_at_four", rd_en, 1'b0);
      tick();
      push_byte(8'h55);
      push_byte(8'h66);
      push_byte(8'h77);
      push_byte(8'h88);
      wait_drain("t1_drain");
      check("t1_second_pkt_seq", last_seq, 8'd1);

      // ---- Test 2: back-pressure for 10 cycles ----
      pkt_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) push_byte(8'($urandom));
      wait_valid("t2_valid_seen");
      tick();
      for (int i = 0; i < 4; i++) push_byte(8'($urandom));
      s0 = sent_pulses;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk1);
         check("t2_valid_during_stall", pkt_valid, 1'b1);
         check("t2_rd_en_during_stall", rd_en, 1'b0);
      end
      tick();
      pkt_ready = 1'b1;
      tick();
      pkt_ready = 1'b0;
      repeat (3) tick();
      check("t2_single_sent_pulse", sent_pulses - s0, 1);
      pkt_ready = 1'b1;
      wait_drain("t2_drain");

`ifdef GPIO_RSP_TIMEOUT_EN
      // ---- Test 3: lone byte is flushed after the idle timeout ----
      tick();
      push_byte(8'hA5);
      emit();
      n = 0;
      while (!pkt_valid && n < 200) begin
         @(negedge clk1);
         n++;
      end
      check("t3_flush_not_early", (n >= TIMEOUT_CYCLES), 1'b1);
      check("t3_flush_not_late",  (n <= TIMEOUT_CYCLES + 8), 1'b1);
      wait_drain("t3_drain");
`else
      // ---- Test 4: lone byte stays buffered without timeout ----
      tick();
      push_byte(8'hA5);
      n = 0;
      repeat (500) begin
         @(negedge clk1);
         if (pkt_valid) n++;
      end
      check("t4_no_partial_packet", n, 0);
      tick();
      for (int i = 0; i < 3; i++) push_byte(8'($urandom));
      wait_drain("t4_drain");
`endif

      // ---- Test 6a: reset after 2 of 4 bytes captured ----
      tick();
      push_byte(8'hC1);
      push_byte(8'hC2);
      repeat (4) tick();
      push_byte(8'hD1);
      push_byte(8'hD2);
      do_reset("t6a");
      tick();
      push_byte(8'hD3);
      push_byte(8'hD4);
      wait_drain("t6a_drain");
      check("t6a_first_seq_after_reset", last_seq, 8'd0);

      // ---- Test 6b: reset with a packet pending ----
      pkt_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) push_byte(8'($urandom));
      wait_valid("t6b_valid_seen");
      tick();
      do_reset("t6b");

      // ---- Test 5: 257 random packets under random back-pressure ----
      for (int p = 0; p < 257; p++) begin
         for (int b = 0; b < PKT_BYTES; b++) begin
            repeat ($urandom_range(0, 2)) rand_tick();
            rand_tick();
            push_byte(8'($urandom));
         end
      end
      pkt_ready = 1'b1;
      wait_drain("t5_drain");
      check("t5_seq_wrapped_on_257th", last_seq, 8'd0);

      repeat (5) tick();
      check("final_scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_gpio_rsp_packer
